keypad_scan: RTL and testbench

- Scans a 4x4 matrix hex keypad by driving columns active-low one at a time and sensing active-low rows.
- Debounces presses and releases, then emits one key event per press.
- Shifts each key's hex code into a 16-bit entry register. The register is sized to feed the seven-segment display driver's 16-bit value input directly.
- This is the input-side counterpart of the display driver, with the same multiplexed one-hot-low scan style.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_tick_gen.sv | 29 ++
 rtl/keypad_scan.sv | 206 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   state_t      - scanner FSM state encoding
//   COLS_IDLE    - column drive with no column selected
//   col_drive()  - one-hot-low column drive for a column index
//   REPEAT_DELAY - ticks before the first auto-repeat (KEYPAD_AUTOREPEAT_EN)
//   REPEAT_RATE  - ticks between subsequent auto-repeats (KEYPAD_AUTOREPEAT_EN)
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] COL0_N    = 4'b1110;
    localparam logic [3:0] COL1_N    = 4'b1101;
    localparam logic [3:0] COL2_N    = 4'b1011;
    localparam logic [3:0] COL3_N    = 4'b0111;
    localparam logic [3:0] COLS_IDLE = 4'b1111;

    localparam int unsigned REPEAT_DELAY = 64;
    localparam int unsigned REPEAT_RATE  = 16;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = COL0_N;
            2'd1:    drv = COL1_N;
            2'd2:    drv = COL2_N;
            default: drv = COL3_N;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running SCAN_DIV-bit divider producing the scan tick.
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   restart - synchronous restart of the divider (counter back to 0)
//   tick    - high for one cycle whenever the counter is all-ones
module keypad_tick_gen #(
    parameter int unsigned SCAN_DIV = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    logic [SCAN_DIV-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == '1) && !restart;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner with debounce and a 16-bit entry register.
//   clk       - system clock
//   reset_n   - asynchronous active-low reset
//   enable    - scanning enabled; low idles the scanner (value/key_code hold)
//   clear     - synchronous clear of the entry register (wins over a shift)
//   rows_n    - row sense, active-low, asynchronous (2-flop synchronized)
//   cols_n    - column drive, one-hot-low, 4'b1111 when idle
//   key_valid - one-cycle strobe per accepted key
//   key_code  - last accepted key, {row_idx, col_idx}
//   value     - entry register, newest digit in [3:0]
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit a held key after
// REPEAT_DELAY ticks and then every REPEAT_RATE ticks.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 8,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [3:0]  rows_n,
    output logic [3:0]  cols_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] value
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_CNT);

    logic [3:0] rows_s1, rows_s2;
    logic       tick;
    state_t     state;
    logic [1:0] col_idx, col_nxt;
    logic [1:0] cand_row, row_idx;
    logic [3:0] deb_cnt, deb_inc;
    logic       one_low, cand_match, all_high;
    logic       adv, emit, rep_emit;
    logic [3:0] emit_code;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (!enable),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rows_s1 <= '1;
            rows_s2 <= '1;
        end else begin
            rows_s1 <= rows_n;
            rows_s2 <= rows_s1;
        end
    end

    always_comb begin
        one_low = 1'b0;
        row_idx = 2'd0;
        case (rows_s2)
            4'b1110: begin one_low = 1'b1; row_idx = 2'd0; end
            4'b1101: begin one_low = 1'b1; row_idx = 2'd1; end
            4'b1011: begin one_low = 1'b1; row_idx = 2'd2; end
            4'b0111: begin one_low = 1'b1; row_idx = 2'd3; end
            default: ;
        endcase
    end

    assign cand_match = (rows_s2 == ~(4'b0001 << cand_row));
    assign all_high   = (rows_s2 == 4'b1111);
    assign deb_inc    = deb_cnt + 4'd1;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [6:0] rep_cnt, rep_inc;

    assign rep_inc  = rep_cnt + 7'd1;
    assign rep_emit = tick && (state == HELD) && cand_match &&
                      (rep_inc == 7'(REPEAT_DELAY));

    // After the first repeat the counter restarts REPEAT_RATE short of the
    // threshold, so later repeats come every REPEAT_RATE ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt <= '0;
        end else if (!enable) begin
            rep_cnt <= '0;
        end else if (tick) begin
            if (state != HELD || !cand_match)
                rep_cnt <= '0;
            else if (rep_emit)
                rep_cnt <= 7'(REPEAT_DELAY - REPEAT_RATE);
            else
                rep_cnt <= rep_inc;
        end
    end
`else
    assign rep_emit = 1'b0;
`endif

    // Column advance and key acceptance are decided here so the column drive
    // can be registered against the next column index without a cycle of lag.
    always_comb begin
        adv  = 1'b0;
        emit = 1'b0;
        if (enable && tick) begin
            case (state)
                SCAN: begin
                    adv  = !one_low;
                    emit = one_low && (DEB == 4'd1);
                end
                DEBOUNCE: begin
                    adv  = !cand_match;
                    emit = cand_match && (deb_inc == DEB);
                end
                HELD: begin
                    adv  = all_high && (deb_inc == DEB);
                    emit = rep_emit;
                end
                default: ;
            endcase
        end
        if (!enable)
            col_nxt = 2'd0;
        else if (adv)
            col_nxt = col_idx + 2'd1;
        else
            col_nxt = col_idx;
        emit_code = (state == SCAN) ? {row_idx, col_idx} : {cand_row, col_idx};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            cols_n    <= COLS_IDLE;
            deb_cnt   <= '0;
            cand_row  <= 2'd0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= emit;
            if (emit)
                key_code <= emit_code;
            col_idx <= col_nxt;
            if (!enable) begin
                state   <= SCAN;
                cols_n  <= COLS_IDLE;
                deb_cnt <= '0;
            end else begin
                cols_n <= col_drive(col_nxt);
                if (tick) begin
                    case (state)
                        SCAN: begin
                            if (one_low) begin
                                cand_row <= row_idx;
                                if (DEB == 4'd1) begin
                                    state   <= HELD;
                                    deb_cnt <= '0;
                                end else begin
                                    state   <= DEBOUNCE;
                                    deb_cnt <= 4'd1;
                                end
                            end
                        end
                        DEBOUNCE: begin
                            if (!cand_match) begin
                                state   <= SCAN;
                                deb_cnt <= '0;
                            end else if (deb_inc == DEB) begin
                                state   <= HELD;
                                deb_cnt <= '0;
                            end else begin
                                deb_cnt <= deb_inc;
                            end
                        end
                        HELD: begin
                            if (!all_high) begin
                                deb_cnt <= '0;
                            end else if (deb_inc == DEB) begin
                                state   <= SCAN;
                                deb_cnt <= '0;
                            end else begin
                                deb_cnt <= deb_inc;
                            end
                        end
                        default: state <= SCAN;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (emit)
            value <= {value[11:0], emit_code};
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan (SCAN_DIV=2, DEBOUNCE_CNT=3).
// A small keypad model pulls a row low while its pressed key's column is driven.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic [3:0]  rows_n;
    logic [3:0]  cols_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value;

    logic [15:0] pressed;   // bit r*4+c: key at row r, column c held down
    int          checks = 0;
    int          passes = 0;
    int          pulse_cnt = 0;
    int          cyc = 0;

    keypad_scan #(
        .SCAN_DIV     (2),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .clear     (clear),
        .rows_n    (rows_n),
        .cols_n    (cols_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .value     (value)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols_n[c])
                    rows_n[r] = 1'b0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (key_valid)
            pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", name, obs, exp);
    endtask

    task automatic wait_pulse(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (key_valid) found = 1'b1;
        end
    endtask

    // Wait for the column drive to switch onto the given pattern.
    task automatic wait_col(input logic [3:0] target, output bit found);
        bit left = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !left; i++) begin
            @(negedge clk);
            if (cols_n != target) left = 1'b1;
        end
        for (int i = 0; i < 40 && left && !found; i++) begin
            @(negedge clk);
            if (cols_n == target) found = 1'b1;
        end
    endtask

    task automatic press_key(input int r, input int c, input logic [15:0] exp_value, input string name);
        bit found;
        pressed[r*4+c] = 1'b1;
        wait_pulse(100, found);
        check({name, "_pulse"}, 16'(found), 16'd1);
        check({name, "_code"}, 16'(key_code), 16'(r*4+c));
        check({name, "_value"}, value, exp_value);
        repeat (8) @(negedge clk);
        pressed[r*4+c] = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        bit found;
        int n0;
        reset_n = 1'b0;
        enable  = 1'b1;
        clear   = 1'b0;
        pressed = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cols", 16'(cols_n), 16'hF);
        check("rst_valid", 16'(key_valid), 16'd0);
        check("rst_code", 16'(key_code), 16'd0);
        check("rst_value", value, 16'h0000);
        reset_n = 1'b1;

        // Reset asserted while debouncing key 9 (row 2, column 1)
        wait_col(4'b1101, found);
        check("col1_reached", 16'(found), 16'd1);
        pressed[9] = 1'b1;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_cols", 16'(cols_n), 16'hF);
        check("midrst_value", value, 16'h0000);
        check("midrst_valid", 16'(key_valid), 16'd0);
        pressed[9] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("restart_cols", 16'(cols_n), 16'hE);

        // Single press of key 9, held well past acceptance
        pressed[9] = 1'b1;
        wait_pulse(100, found);
        check("single_pulse", 16'(found), 16'd1);
        check("single_code", 16'(key_code), 16'h9);
        check("single_value", value, 16'h0009);
        n0 = pulse_cnt + 1;
        repeat (60) @(negedge clk);
        check("single_no_repeat", 16'(pulse_cnt), 16'(n0));
        pressed[9] = 1'b0;
        repeat (40) @(negedge clk);

        // Digit entry 1..5
        press_key(0, 1, 16'h0091, "dig1");
        press_key(0, 2, 16'h0912, "dig2");
        press_key(0, 3, 16'h9123, "dig3");
        press_key(1, 0, 16'h1234, "dig4");
        press_key(1, 1, 16'h2345, "dig5");

        // Bounce: key 9 toggled each tick period, never stable for 3 ticks
        n0 = pulse_cnt;
        wait_col(4'b1101, found);
        pressed[9] = 1'b1; repeat (4) @(negedge clk);
        pressed[9] = 1'b0; repeat (4) @(negedge clk);
        pressed[9] = 1'b1; repeat (4) @(negedge clk);
        pressed[9] = 1'b0; repeat (40) @(negedge clk);
        check("bounce_no_event", 16'(pulse_cnt), 16'(n0));
        wait_col(4'b1110, found);
        check("bounce_scanning", 16'(found), 16'd1);

        // Two rows low in column 2
        n0 = pulse_cnt;
        pressed[2]  = 1'b1;
        pressed[14] = 1'b1;
        repeat (80) @(negedge clk);
        check("tworow_no_event", 16'(pulse_cnt), 16'(n0));
        wait_col(4'b0111, found);
        check("tworow_scanning", 16'(found), 16'd1);
        pressed[2]  = 1'b0;
        pressed[14] = 1'b0;
        repeat (40) @(negedge clk);

        // Clear held across the acceptance of key 6
        clear = 1'b1;
        press_key(1, 2, 16'h0000, "clr");
        clear = 1'b0;
        press_key(1, 3, 16'h0007, "key7");

        // Enable dropped for 10 cycles, key F pressed meanwhile
        n0 = pulse_cnt;
        enable = 1'b0;
        pressed[15] = 1'b1;
        @(negedge clk);
        check("dis_cols_first", 16'(cols_n), 16'hF);
        repeat (9) @(negedge clk);
        check("dis_cols_last", 16'(cols_n), 16'hF);
        check("dis_value", value, 16'h0007);
        check("dis_code", 16'(key_code), 16'h7);
        check("dis_no_event", 16'(pulse_cnt), 16'(n0));
        pressed[15] = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check("reen_cols", 16'(cols_n), 16'hE);
        repeat (20) @(negedge clk);

`ifdef KEYPAD_AUTOREPEAT_EN
        begin
            int t0;
            int nrep;
            int stamp [3];
            pressed[10] = 1'b1;
            wait_pulse(100, found);
            check("rep_accept", 16'(found), 16'd1);
            check("rep_code", 16'(key_code), 16'hA);
            t0 = cyc;
            nrep = 0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (key_valid) begin
                    if (nrep < 3) stamp[nrep] = cyc - t0;
                    nrep++;
                end
            end
            check("rep_count", 16'(nrep), 16'd3);
            check("rep_first", 16'(stamp[0]), 16'd256);
            check("rep_second", 16'(stamp[1]), 16'd320);
            check("rep_third", 16'(stamp[2]), 16'd384);
            pressed[10] = 1'b0;
            repeat (40) @(negedge clk);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
